// File: rtl/elevator_dispatcher.sv
// SCAN-order elevator dispatcher: latches floor calls, drives the car's direction
// and door commands, and faults if the car does not follow door commands.
module elevator_dispatcher #(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [2:0]            floor,
    input  logic                  door,
    output logic [1:0]            updown,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  fault,
    output logic [2:0]            fsm_state
);
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > ACK_TIMEOUT) ? DWELL_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0] TMO_LAST   = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MOVE_UP    = 3'd1,
        MOVE_DOWN  = 3'd2,
        DOOR_REQ   = 3'd3,
        DWELL      = 3'd4,
        DOOR_CLOSE = 3'd5,
        FAULT      = 3'd6
    } state_t;

    state_t                state, state_d;
    logic                  dir, dir_d;  // 1 = up
    logic [CW-1:0]         cnt, cnt_d;
    logic [NUM_FLOORS-1:0] pending_d, here_mask, clr, latch_mask;
    logic                  any_above, any_below, here, call_here, floor_bad;
    logic                  ahead, behind;
    logic [1:0]            updown_d;
    logic                  door_open_d, busy_d, fault_d;

    always_comb begin
        here_mask = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (i == 32'(floor)) here_mask[i] = 1'b1;
            if (i > 32'(floor) && pending[i]) any_above = 1'b1;
            if (i < 32'(floor) && pending[i]) any_below = 1'b1;
        end
    end

    assign here      = |(pending & here_mask);
    assign call_here = |(call_req & here_mask);
    assign floor_bad = 32'(floor) >= NUM_FLOORS;
    assign ahead     = dir ? any_above : any_below;
    assign behind    = dir ? any_below : any_above;

    always_comb begin
        state_d = state;
        dir_d   = dir;
        cnt_d   = cnt;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (here) state_d = DOOR_REQ;
                else if (any_above) begin state_d = MOVE_UP; dir_d = 1'b1; end
                else if (any_below) begin state_d = MOVE_DOWN; dir_d = 1'b0; end
            end
            MOVE_UP: begin
                if (door) state_d = FAULT;
                else if (here) state_d = DOOR_REQ;
                else if (!any_above) state_d = IDLE;
            end
            MOVE_DOWN: begin
                if (door) state_d = FAULT;
                else if (here) state_d = DOOR_REQ;
                else if (!any_below) state_d = IDLE;
            end
            DOOR_REQ: begin
                if (door) state_d = DWELL;
                else if (cnt == TMO_LAST) state_d = FAULT;
                else cnt_d = cnt + 1'b1;
            end
            DWELL: begin
                if (call_here) cnt_d = DWELL_LOAD;
                else if (cnt == CW'(1)) state_d = DOOR_CLOSE;
                else cnt_d = cnt - 1'b1;
            end
            DOOR_CLOSE: begin
                if (door) begin
                    if (cnt == TMO_LAST) state_d = FAULT;
                    else cnt_d = cnt + 1'b1;
                end else if (ahead) begin
                    state_d = dir ? MOVE_UP : MOVE_DOWN;
                end else if (behind) begin
                    state_d = dir ? MOVE_DOWN : MOVE_UP;
                    dir_d   = ~dir;
                end else if (here) begin
                    state_d = DOOR_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
        if (state != FAULT && floor_bad) state_d = FAULT;
        // Every state entry restarts the shared dwell/timeout counter.
        if (state_d != state) cnt_d = (state_d == DWELL) ? DWELL_LOAD : '0;
        if (state_d == DOOR_REQ && state != DOOR_REQ) clr = here_mask;
    end

    assign latch_mask = (state == DOOR_REQ || state == DWELL) ? here_mask : '0;
    assign pending_d  = (state == FAULT) ? pending
                      : (pending | (call_req & ~latch_mask)) & ~clr;

    always_comb begin
        updown_d    = 2'b00;
        door_open_d = 1'b0;
        busy_d      = 1'b1;
        fault_d     = 1'b0;
        case (state_d)
            MOVE_UP:         updown_d = 2'b01;
            MOVE_DOWN:       updown_d = 2'b10;
            DOOR_REQ, DWELL: door_open_d = 1'b1;
            IDLE:            busy_d = 1'b0;
            FAULT: begin
                busy_d  = 1'b0;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir       <= 1'b1;
            cnt       <= '0;
            pending   <= '0;
            updown    <= 2'b00;
            door_open <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            dir       <= dir_d;
            cnt       <= cnt_d;
            pending   <= pending_d;
            updown    <= updown_d;
            door_open <= door_open_d;
            busy      <= busy_d;
            fault     <= fault_d;
        end
    end

    assign fsm_state = state;

    a_no_overtravel: assert property (@(posedge clk) disable iff (!rst_n)
        !(updown_d == 2'b01 && 32'(floor) == NUM_FLOORS - 1) &&
        !(updown_d == 2'b10 && floor == 3'd0) && updown_d != 2'b11);

endmodule
